onewire_sequencer: RTL and testbench

Transaction sequencer for the 1-Wire `output_driver`. It accepts a command consisting of an optional bus reset/presence slot followed by 0..MAX_BYTES data bytes. It pulls each byte over a valid/ready stream and serialises it LSB-first as single-bit strobes to the driver. It waits for driver completion between slots, enforces a per-slot timeout, and reports done/error to the host-side controller.

---
 rtl/onewire_pkg.sv | 17 +
 rtl/onewire_sequencer_if.sv | 40 ++++
 rtl/onewire_slot_timer.sv | 40 ++++
 rtl/onewire_sequencer.sv | 146 ++++++++++++++
 tb/tb_onewire_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: sequencer state encoding and byte geometry.
// Also used by output_driver and the future read-slot logic.
package onewire_pkg;

   localparam int unsigned BIT_PER_BYTE = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRstIssue,
      StRstWait,
      StLoad,
      StBitIssue,
      StBitWait,
      StDone
   } seq_state_e;

endpackage

// File: rtl/onewire_sequencer_if.sv
// Signal bundle between the 1-Wire sequencer, its host-side controller and output_driver.
//   command stream : i_cmd_valid/i_cmd_rst/i_cmd_count -> o_cmd_ready
//   byte stream    : i_byte_valid/i_byte -> o_byte_ready
//   driver         : o_drv_start/o_drv_bit_strobe/o_drv_serial <- i_drv_busy/i_drv_done
//   status         : o_busy, o_done, o_error
// modport master: the sequencer; modport slave: host and driver side.
interface onewire_sequencer_if #(
   parameter int unsigned MAX_BYTES = 16
);
   localparam int unsigned BC_W = $clog2(MAX_BYTES + 1);

   logic            i_cmd_valid;
   logic            i_cmd_rst;
   logic [BC_W-1:0] i_cmd_count;
   logic            o_cmd_ready;
   logic            i_byte_valid;
   logic [7:0]      i_byte;
   logic            o_byte_ready;
   logic            o_drv_start;
   logic            o_drv_bit_strobe;
   logic            o_drv_serial;
   logic            i_drv_busy;
   logic            i_drv_done;
   logic            o_busy;
   logic            o_done;
   logic            o_error;

   modport master (
      input  i_cmd_valid, i_cmd_rst, i_cmd_count, i_byte_valid, i_byte, i_drv_busy, i_drv_done,
      output o_cmd_ready, o_byte_ready, o_drv_start, o_drv_bit_strobe, o_drv_serial,
             o_busy, o_done, o_error
   );

   modport slave (
      output i_cmd_valid, i_cmd_rst, i_cmd_count, i_byte_valid, i_byte, i_drv_busy, i_drv_done,
      input  o_cmd_ready, o_byte_ready, o_drv_start, o_drv_bit_strobe, o_drv_serial,
             o_busy, o_done, o_error
   );

endinterface

// File: rtl/onewire_slot_timer.sv
// Per-slot timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force count to zero (held while not waiting on a slot)
//   enable     : count one wait cycle
//   expired    : count has reached TIMEOUT_CYC-1
module onewire_slot_timer #(
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/onewire_sequencer.sv
// 1-Wire transaction sequencer: optional bus-reset slot, then 0..MAX_BYTES bytes pulled over
// a valid/ready stream and sent LSB-first as single-bit strobes to output_driver. Each slot
// waits for driver completion under a timeout; done/error reported to the host.
//   clk, reset : clock, synchronous active-high reset
//   bus        : onewire_sequencer_if.master (command, byte, driver and status signals)
module onewire_sequencer #(
   parameter int unsigned MAX_BYTES   = 16,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input logic                 clk,
   input logic                 reset,
   onewire_sequencer_if.master bus
);
   import onewire_pkg::*;

   localparam int unsigned BC_W = $clog2(MAX_BYTES + 1);
   localparam logic [BC_W-1:0] MAX_COUNT = BC_W'(MAX_BYTES);
   localparam logic [2:0] LAST_BIT = 3'(BIT_PER_BYTE - 1);

   seq_state_e      state_q, state_d;
   logic [BC_W-1:0] count_q, count_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            seen_done_q, seen_done_d;
   logic            err_q, err_d;
   logic            serial_q, serial_d;
   logic            slot_complete;
   logic            waiting;
   logic            expired;

   assign waiting = (state_q == StRstWait) || (state_q == StBitWait);
   // A done pulse arriving together with busy low finishes the slot in that same cycle.
   assign slot_complete = (seen_done_q || bus.i_drv_done) && !bus.i_drv_busy;

   onewire_slot_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!waiting),
      .enable  (waiting),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      byte_cnt_d  = byte_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      seen_done_d = 1'b0;
      err_d       = err_q;
      serial_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            err_d = 1'b0;
            if (bus.i_cmd_valid) begin
               count_d    = (bus.i_cmd_count > MAX_COUNT) ? MAX_COUNT : bus.i_cmd_count;
               byte_cnt_d = '0;
               if (bus.i_cmd_rst)       state_d = StRstIssue;
               else if (count_d != '0)  state_d = StLoad;
               else                     state_d = StDone;
            end
         end
         StRstIssue: state_d = StRstWait;
         StRstWait: begin
            seen_done_d = seen_done_q || bus.i_drv_done;
            if (slot_complete) begin
               state_d = (count_q != '0) ? StLoad : StDone;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StLoad: begin
            if (bus.i_byte_valid) begin
               shift_d   = bus.i_byte;
               bit_cnt_d = '0;
               serial_d  = bus.i_byte[0];
               state_d   = StBitIssue;
            end
         end
         StBitIssue: begin
            serial_d = serial_q;
            state_d  = StBitWait;
         end
         StBitWait: begin
            seen_done_d = seen_done_q || bus.i_drv_done;
            serial_d    = serial_q;
            if (slot_complete) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  serial_d   = 1'b0;
                  state_d    = (byte_cnt_d == count_q) ? StDone : StLoad;
               end else begin
                  // Next bit goes out on the following strobe; preload it here.
                  serial_d = shift_q[1];
                  state_d  = StBitIssue;
               end
            end else if (expired) begin
               err_d    = 1'b1;
               serial_d = 1'b0;
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         byte_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         seen_done_q <= 1'b0;
         err_q       <= 1'b0;
         serial_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         byte_cnt_q  <= byte_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         seen_done_q <= seen_done_d;
         err_q       <= err_d;
         serial_q    <= serial_d;
      end
   end

   assign bus.o_cmd_ready      = (state_q == StIdle);
   assign bus.o_byte_ready     = (state_q == StLoad);
   assign bus.o_drv_start      = (state_q == StRstIssue);
   assign bus.o_drv_bit_strobe = (state_q == StBitIssue);
   assign bus.o_drv_serial     = serial_q;
   assign bus.o_busy           = (state_q != StIdle);
   assign bus.o_done           = (state_q == StDone);
   assign bus.o_error          = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_onewire_sequencer.sv
// Scoreboard bench for onewire_sequencer: stimulus pushes expected start/bit/done events into
// queues, a monitor pops them as the DUT produces strobes and done pulses.
module tb_onewire_sequencer;

   localparam int unsigned MAX_BYTES   = 16;
   localparam int unsigned TIMEOUT_CYC = 64;
   localparam int unsigned BC_W        = $clog2(MAX_BYTES + 1);

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   onewire_sequencer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

   onewire_sequencer #(
      .MAX_BYTES   (MAX_BYTES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   bit start_q[$];
   bit bit_q[$];
   bit done_q[$];

   // driver model controls
   int rst_delay  = 10;
   int bit_delay  = 4;
   int hang_at    = -1;
   int strobe_idx = 0;
   int hang_cycle = 0;
   bit hang_seen  = 1'b0;
   bit late_busy  = 1'b0;
   bit drv_abort  = 1'b0;
   bit ready_after_hang = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver model: busy after each request, done pulse after a delay, optionally never.
   initial begin
      int dly;
      bit hung;
      bus.i_drv_busy = 1'b0;
      bus.i_drv_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.i_drv_done = 1'b0;
         if (!reset && (bus.o_drv_start || bus.o_drv_bit_strobe)) begin
            hung = 1'b0;
            dly  = bus.o_drv_start ? rst_delay : bit_delay;
            if (bus.o_drv_bit_strobe) begin
               if (strobe_idx == hang_at) begin
                  hung       = 1'b1;
                  hang_cycle = cyc;
                  hang_seen  = 1'b1;
               end
               strobe_idx++;
            end
            bus.i_drv_busy = 1'b1;
            if (hung) begin
               while (!drv_abort) @(negedge clk);
            end else begin
               for (int k = 0; k < dly && !drv_abort; k++) @(negedge clk);
               if (!drv_abort) begin
                  bus.i_drv_done = 1'b1;
                  if (late_busy) begin
                     @(negedge clk);
                     bus.i_drv_done = 1'b0;
                     @(negedge clk);
                  end
               end
            end
            bus.i_drv_busy = 1'b0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      bit exp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.o_drv_start) begin
               if (start_q.size() == 0) check("unexpected o_drv_start", 1, 0);
               else begin
                  exp = start_q.pop_front();
                  check("o_drv_start expected", bus.o_drv_start, exp);
               end
            end
            if (bus.o_drv_bit_strobe) begin
               if (bit_q.size() == 0) check("unexpected o_drv_bit_strobe", 1, 0);
               else begin
                  exp = bit_q.pop_front();
                  check("o_drv_serial on strobe", bus.o_drv_serial, exp);
               end
            end
            if (bus.o_done) begin
               if (done_q.size() == 0) check("unexpected o_done", 1, 0);
               else begin
                  exp = done_q.pop_front();
                  check("o_error on o_done", bus.o_error, exp);
                  check("bit strobes missing at o_done", bit_q.size(), 0);
                  check("reset slots missing at o_done", start_q.size(), 0);
               end
            end
            if (bus.o_error && !bus.o_done) check("o_error without o_done", 1, 0);
            if ((bus.o_cmd_ready || bus.o_byte_ready || bus.o_drv_start || bus.o_done) &&
                bus.o_drv_serial) begin
               check("o_drv_serial outside bit slot", bus.o_drv_serial, 0);
            end
            if (hang_seen && bus.o_byte_ready) ready_after_hang = 1'b1;
         end
      end
   end

   task automatic send_cmd(input bit r, input int cnt, input bit err);
      int w = 0;
      while (!bus.o_cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("o_cmd_ready before command", bus.o_cmd_ready, 1);
      if (r) start_q.push_back(1'b1);
      done_q.push_back(err);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_rst   = r;
      bus.i_cmd_count = BC_W'(cnt);
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
      check("o_busy after accept", bus.o_busy, 1);
      check("o_drv_start one cycle after accept", bus.o_drv_start, r);
   endtask

   task automatic send_byte(input logic [7:0] b, input int delay, input int nbits);
      int w = 0;
      while (!bus.o_byte_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("o_byte_ready reached", bus.o_byte_ready, 1);
      repeat (delay) @(negedge clk);
      check("o_error while stalled in load", bus.o_error, 0);
      for (int i = 0; i < nbits; i++) bit_q.push_back(b[i]);
      bus.i_byte_valid = 1'b1;
      bus.i_byte       = b;
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
      check("o_drv_bit_strobe one cycle after byte accept", bus.o_drv_bit_strobe, 1);
   endtask

   task automatic wait_done(output int at);
      int w = 0;
      while (!bus.o_done && w < 3000) begin
         @(negedge clk);
         w++;
      end
      at = cyc;
      check("o_done reached", bus.o_done, 1);
      @(negedge clk);
      check("o_cmd_ready after o_done", bus.o_cmd_ready, 1);
      check("o_done single cycle", bus.o_done, 0);
   endtask

   task automatic release_driver();
      drv_abort = 1'b1;
      repeat (2) @(negedge clk);
      drv_abort = 1'b0;
   endtask

   initial begin
      int done_at;
      logic [7:0] bytes3 [3];
      bytes3[0] = 8'hCC;
      bytes3[1] = 8'h44;
      bytes3[2] = 8'h0F;

      reset            = 1'b1;
      bus.i_cmd_valid  = 1'b0;
      bus.i_cmd_rst    = 1'b0;
      bus.i_cmd_count  = '0;
      bus.i_byte_valid = 1'b0;
      bus.i_byte       = '0;
      repeat (3) @(negedge clk);
      check("reset o_cmd_ready", bus.o_cmd_ready, 1);
      check("reset o_busy", bus.o_busy, 0);
      check("reset o_done", bus.o_done, 0);
      check("reset o_error", bus.o_error, 0);
      check("reset o_byte_ready", bus.o_byte_ready, 0);
      check("reset o_drv_start", bus.o_drv_start, 0);
      check("reset o_drv_bit_strobe", bus.o_drv_bit_strobe, 0);
      check("reset o_drv_serial", bus.o_drv_serial, 0);
      reset = 1'b0;
      @(negedge clk);

      // reset slot only
      rst_delay = 50;
      send_cmd(1'b1, 0, 1'b0);
      wait_done(done_at);

      // single byte 0xA5 -> 1,0,1,0,0,1,0,1
      rst_delay = 10;
      send_cmd(1'b0, 1, 1'b0);
      send_byte(8'hA5, 0, 8);
      wait_done(done_at);

      // reset + 3 stalled bytes, done pulse arrives before busy drops
      late_busy = 1'b1;
      send_cmd(1'b1, 3, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(bytes3[i], 20, 8);
      wait_done(done_at);
      late_busy = 1'b0;

      // timeout on bit 3 of 0xFF; second byte never requested
      hang_at = strobe_idx + 3;
      send_cmd(1'b0, 2, 1'b1);
      send_byte(8'hFF, 0, 4);
      wait_done(done_at);
      check("timeout o_done latency from hung strobe", done_at - hang_cycle, TIMEOUT_CYC + 1);
      repeat (10) @(negedge clk);
      check("o_byte_ready after timeout", ready_after_hang, 0);
      hang_seen = 1'b0;
      hang_at   = -1;
      release_driver();

      // reset asserted during bit wait of byte 2
      send_cmd(1'b0, 3, 1'b0);
      send_byte(8'h11, 0, 8);
      send_byte(8'h22, 0, 8);
      @(negedge clk);
      reset = 1'b1;
      bit_q.delete();
      done_q.delete();
      start_q.delete();
      drv_abort = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("o_busy after mid-command reset", bus.o_busy, 0);
      check("o_cmd_ready after mid-command reset", bus.o_cmd_ready, 1);
      check("o_done after mid-command reset", bus.o_done, 0);
      check("o_drv_bit_strobe after mid-command reset", bus.o_drv_bit_strobe, 0);
      @(negedge clk);
      drv_abort = 1'b0;
      repeat (5) @(negedge clk);
      send_cmd(1'b1, 1, 1'b0);
      send_byte(8'h3C, 0, 8);
      wait_done(done_at);

      // count above MAX_BYTES clamps to 16; command offered while busy is dropped
      send_cmd(1'b0, 20, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            check("o_busy during command", bus.o_busy, 1);
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_rst   = 1'b1;
            bus.i_cmd_count = BC_W'(1);
            @(negedge clk);
            bus.i_cmd_valid = 1'b0;
         end
         send_byte(8'(i * 37 + 5), 0, 8);
      end
      wait_done(done_at);
      repeat (10) @(negedge clk);
      check("o_busy after clamped command", bus.o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required completion (total=%0d bad=%0d)",
               total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
